dsp_dual_mac: RTL and testbench
===============================

# dsp_dual_mac

Parametrised dual multiply-accumulate unit for the convolution datapath. Two signed operands `a` and `b` share one unsigned operand `c`, such as a common activation. Both products are computed in a single packed wide multiply and split with a borrow correction. Results are either emitted per beat or accumulated over a vector delimited by `in_last`. It generalises `dsp_dual_mult` by adding width parameters, accumulation, saturation, beat counting and overflow flagging.

## Interface
- `DATA_W`, 8: width of `a`, `b` (signed) and `c` (unsigned).
- `ACC_W`, 24: accumulator and output width; must be ≥ 2*DATA_W.
- `CNT_W`, 8: width of the beat counter.
- `SATURATE`, 1: 1 = clamp the accumulators; 0 = modular wrap.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: global clock enable; when low, all pipeline state freezes.
- `in_valid`  in  1: beat is valid and accepted. There is no backpressure.
- `in_last`  in  1: last beat of the vector (used only when `acc_mode`=1).
- `acc_mode`  in  1: 1 = accumulate over the vector; 0 = per-beat product.
- `a`, `b`  in  DATA_W: signed multiplicands.
- `c`  in  DATA_W: unsigned shared multiplier, zero-extended.
- `ac`, `bc`  out  ACC_W: signed results.
- `out_count`  out  CNT_W: beats contributing to the result; saturates at 2^CNT_W−1.
- `out_ovf`  out  1: sticky flag, set if either accumulator clamped or wrapped in this vector.
- `out_valid`  out  1: one-cycle result strobe.

## Operation
- Packed product: P = ((a <<< S) + b) * c, with S = 2*DATA_W+2.
  - bc = sext(P[S-1:0]) reduced to 2*DATA_W bits.
  - ac = P[upper:S] + P[S-1], the borrow correction.
  - Both are exact signed 2*DATA_W results for all operand combinations.
- Products are sign-extended to ACC_W before accumulation.
- `acc_mode`=1:
  - The first beat of a vector loads the accumulators with its products.
  - Later beats add their products.
  - The beat with `in_last`=1 produces the output; the next valid beat starts a new vector.
- `acc_mode`=0:
  - The beat is a complete vector by itself: it outputs its own products with `out_count`=1.
  - Any partially accumulated vector is discarded, and the next beat starts fresh.
- `SATURATE`=1: an add overflowing ACC_W clamps to +2^(ACC_W−1)−1 or −2^(ACC_W−1), and sets `out_ovf`.
- `SATURATE`=0: an overflowing add wraps and sets `out_ovf`.
- Each vector resets the overflow flag and the counter.
- While `en`=0, beats are ignored and no state changes (outputs hold). `out_valid` is gated by `en`: a strobe is never repeated.
- Reset clears all pipeline registers, accumulators, the counter and the flag.
  - Outputs `ac`, `bc`, `out_count` = 0; `out_ovf` = 0; `out_valid` = 0.
  - A vector in flight when reset hits is lost. The first valid beat after reset starts a new vector.

## Timing
- Four register stages:
  - S1: input register.
  - S2: packed multiply.
  - S3: split and correct.
  - S4: accumulate and output.
- Latency: `out_valid` rises 4 enabled cycles after the closing beat (the `in_last` beat, or an `acc_mode`=0 beat) is sampled.
- Throughput: one beat per cycle. Back-to-back vectors are allowed, including a single-beat `in_last` vector right after another vector closes.
- `in_valid` low cycles (bubbles) inside a vector are allowed and do not change the accumulators.
- Outputs are registered and hold their last value until the next strobe.

## Structure
- Package `dsp_pkg`:
  - `pack_shift(DATA_W)` function.
  - `sat_add` function (signed add with clamp and overflow flag).
  - Stage-count constant `DSP_MAC_LAT = 4`.
- Sub-module `dsp_packed_mult` covers stages S1–S3. It is reusable by `dsp_dual_mult` and future blocks.
- `dsp_dual_mac` adds the valid/last pipeline, the accumulators, the counter and the flag.

## Test plan
- Per-beat: `acc_mode`=0, a=−3, b=5, c=200 → 4 cycles later ac=−600, bc=1000, `out_count`=1, `out_ovf`=0.
- Corner products: a=−128, b=−128, c=255 → ac=bc=−32640. a=127, b=−128, c=0 → ac=bc=0.
- Accumulate: `acc_mode`=1, 3 beats (a,b,c) = (1,2,10), (−4,3,5), (7,−1,1) with bubbles between them.
  - Expect `in_last` +4 → ac=−3, bc=34, `out_count`=3, one strobe only.
- Saturation and wrap: ACC_W=16, a=b=127, c=255, two-beat vector.
  - `SATURATE`=1 → ac=bc=32767, `out_ovf`=1.
  - `SATURATE`=0 → ac=bc=−766, `out_ovf`=1.
  - The next single-beat vector shows `out_ovf`=0.
- Stall and reset:
  - Drop `en` for 5 cycles mid-vector → result and latency are shifted by exactly 5 cycles.
  - Assert `rst` mid-vector → all outputs go to 0 immediately, no strobe.
  - The next vector's result excludes the pre-reset beats.
- Randomised: 1000 random beats, random `in_last` and `acc_mode`, checked against a reference model sign-extending a and b and zero-extending c.

Source files
------------

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared constants and arithmetic helpers for the DSP MAC datapath
package dsp_pkg;

    localparam int DSP_MAC_LAT = 4;
    localparam int SAT_W       = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_res_t;

    // Guard field between the two packed products: wide enough that the lower
    // signed product never bleeds into the upper one beyond a single borrow.
    function automatic int pack_shift(input int data_w);
        return 2 * data_w + 2;
    endfunction

    // Operands are sign-extended acc_w-bit values; the result is acc_w-bit
    // clamped (sat=1) or wrapped (sat=0), sign-extended back to SAT_W.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] y,
        input int                      acc_w,
        input logic                    sat
    );
        logic signed [SAT_W-1:0] full;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        full  = x + y;
        hi    = (SAT_W'(1) <<< (acc_w - 1)) - SAT_W'(1);
        lo    = ~hi;
        r.ovf = (full > hi) || (full < lo);
        if (!r.ovf) begin
            r.sum = full;
        end else if (sat) begin
            r.sum = full[SAT_W-1] ? lo : hi;
        end else begin
            r.sum = (full <<< (SAT_W - acc_w)) >>> (SAT_W - acc_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_packed_mult.sv
// rtl/dsp_packed_mult.sv - two signed-by-unsigned products from one packed multiply (S1-S3)
module dsp_packed_mult
    import dsp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [DATA_W-1:0]     c,
    output logic [2*DATA_W-1:0]   ac,
    output logic [2*DATA_W-1:0]   bc
);

    localparam int S  = pack_shift(DATA_W);
    localparam int PW = DATA_W + S + 1;
    localparam int MW = PW + DATA_W + 1;
    localparam int RW = 2 * DATA_W;

    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    c_q;
    logic [MW-1:0]        prod_q;
    logic signed [PW-1:0] packed_w;
    logic signed [MW-1:0] prod_w;
    logic [RW-1:0]        ac_w;
    logic [RW-1:0]        bc_w;

    always_comb begin
        packed_w = (PW'($signed(a_q)) <<< S) + PW'($signed(b_q));
        prod_w   = MW'(packed_w) * MW'($signed({1'b0, c_q}));
    end

    // A negative lower product borrows one from the upper field; its sign bit
    // is exactly that borrow, so adding it back restores a*c.
    always_comb begin
        bc_w = RW'(prod_q[S-1:0]);
        ac_w = RW'(prod_q[MW-1:S]) + RW'(prod_q[S-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            prod_q <= '0;
            ac     <= '0;
            bc     <= '0;
        end else if (en) begin
            a_q    <= a;
            b_q    <= b;
            c_q    <= c;
            prod_q <= MW'(prod_w);
            ac     <= ac_w;
            bc     <= bc_w;
        end
    end

endmodule

// File: rtl/dsp_dual_mac.sv
// rtl/dsp_dual_mac.sv - dual signed MAC sharing one unsigned operand, with vector accumulation
module dsp_dual_mac
    import dsp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              acc_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [ACC_W-1:0]  ac,
    output logic [ACC_W-1:0]  bc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid
);

    localparam int RW = 2 * DATA_W;
    localparam int CW = DSP_MAC_LAT - 1;

    logic [RW-1:0]           p_ac;
    logic [RW-1:0]           p_bc;
    logic [CW-1:0]           v_pipe;
    logic [CW-1:0]           l_pipe;
    logic [CW-1:0]           m_pipe;

    logic signed [ACC_W-1:0] acc_a;
    logic signed [ACC_W-1:0] acc_b;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    fresh;

    logic signed [ACC_W-1:0] ext_a;
    logic signed [ACC_W-1:0] ext_b;
    logic signed [ACC_W-1:0] acc_a_nxt;
    logic signed [ACC_W-1:0] acc_b_nxt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    ovf_nxt;
    logic                    beat;
    logic                    start;
    logic                    closing;
    sat_res_t                res_a;
    sat_res_t                res_b;

    dsp_packed_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .a   (a),
        .b   (b),
        .c   (c),
        .ac  (p_ac),
        .bc  (p_bc)
    );

    // Beat qualifiers travel alongside the three multiplier stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            l_pipe <= '0;
            m_pipe <= '0;
        end else if (en) begin
            v_pipe <= {v_pipe[CW-2:0], in_valid};
            l_pipe <= {l_pipe[CW-2:0], in_last};
            m_pipe <= {m_pipe[CW-2:0], acc_mode};
        end
    end

    always_comb begin
        beat    = v_pipe[CW-1];
        start   = fresh || !m_pipe[CW-1];
        closing = !m_pipe[CW-1] || l_pipe[CW-1];
        ext_a   = ACC_W'($signed(p_ac));
        ext_b   = ACC_W'($signed(p_bc));
        res_a   = sat_add(SAT_W'(acc_a), SAT_W'(ext_a), ACC_W, SATURATE != 0);
        res_b   = sat_add(SAT_W'(acc_b), SAT_W'(ext_b), ACC_W, SATURATE != 0);
        if (start) begin
            acc_a_nxt = ext_a;
            acc_b_nxt = ext_b;
            cnt_nxt   = CNT_W'(1);
            ovf_nxt   = 1'b0;
        end else begin
            acc_a_nxt = ACC_W'($signed(res_a.sum));
            acc_b_nxt = ACC_W'($signed(res_b.sum));
            cnt_nxt   = (&cnt) ? cnt : cnt + 1'b1;
            ovf_nxt   = ovf | res_a.ovf | res_b.ovf;
        end
    end

    // out_valid is cleared on stalled cycles so a strobe never repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_a     <= '0;
            acc_b     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            fresh     <= 1'b1;
            ac        <= '0;
            bc        <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en && beat && closing;
            if (en && beat) begin
                acc_a <= acc_a_nxt;
                acc_b <= acc_b_nxt;
                cnt   <= cnt_nxt;
                ovf   <= ovf_nxt;
                fresh <= closing;
                if (closing) begin
                    ac        <= acc_a_nxt;
                    bc        <= acc_b_nxt;
                    out_count <= cnt_nxt;
                    out_ovf   <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_dual_mac.sv
// tb/tb_dsp_dual_mac.sv - scoreboard bench for dsp_dual_mac, saturating and wrapping variants
module tb_dsp_dual_mac;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 3;
    localparam int LAT    = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int HI     = (1 << (ACC_W - 1)) - 1;
    localparam int LO     = -(1 << (ACC_W - 1));

    logic              clk = 1'b0;
    logic              rst, en, in_valid, in_last, acc_mode;
    logic [DATA_W-1:0] a, b, c;
    logic [ACC_W-1:0]  ac_s, bc_s, ac_w, bc_w;
    logic [CNT_W-1:0]  cnt_s, cnt_w;
    logic              ovf_s, ovf_w, vld_s, vld_w;

    always #5 clk = ~clk;

    dsp_dual_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .acc_mode(acc_mode), .a(a), .b(b), .c(c), .ac(ac_s), .bc(bc_s),
        .out_count(cnt_s), .out_ovf(ovf_s), .out_valid(vld_s));

    dsp_dual_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .acc_mode(acc_mode), .a(a), .b(b), .c(c), .ac(ac_w), .bc(bc_w),
        .out_count(cnt_w), .out_ovf(ovf_w), .out_valid(vld_w));

    typedef struct {
        int sa, sb, wa, wb, cnt;
        bit os, ow;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0, n_fail = 0, cyc = 0, n_push = 0, n_strobe = 0;
    bit   m_fresh = 1'b1;
    int   m_sa, m_sb, m_wa, m_wb, m_cnt;
    bit   m_os, m_ow;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ovf_ref(input int x, input int y);
        return (x + y > HI) || (x + y < LO);
    endfunction

    function automatic int add_ref(input int x, input int y, input bit sat);
        int               s;
        logic [ACC_W-1:0] t;
        s = x + y;
        if (s >= LO && s <= HI) return s;
        if (sat) return (s > HI) ? HI : LO;
        t = s[ACC_W-1:0];
        return int'($signed(t));
    endfunction

    task automatic model_beat(input bit l, input bit m, input int av, input int bv, input int cv);
        int   pa, pb;
        exp_t e;
        pa = av * cv;
        pb = bv * cv;
        if (m_fresh || !m) begin
            m_sa = pa; m_sb = pb; m_wa = pa; m_wb = pb;
            m_cnt = 1; m_os = 0; m_ow = 0;
        end else begin
            m_os  = m_os | ovf_ref(m_sa, pa) | ovf_ref(m_sb, pb);
            m_ow  = m_ow | ovf_ref(m_wa, pa) | ovf_ref(m_wb, pb);
            m_sa  = add_ref(m_sa, pa, 1'b1);
            m_sb  = add_ref(m_sb, pb, 1'b1);
            m_wa  = add_ref(m_wa, pa, 1'b0);
            m_wb  = add_ref(m_wb, pb, 1'b0);
            m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end
        m_fresh = !m || l;
        if (m_fresh) begin
            e = '{sa: m_sa, sb: m_sb, wa: m_wa, wb: m_wb, cnt: m_cnt, os: m_os, ow: m_ow, due: cyc + LAT};
            sb_q.push_back(e);
            n_push++;
        end
    endtask

    task automatic drive(input bit e, input bit v, input bit l, input bit m,
                         input int av, input int bv, input int cv);
        en = e; in_valid = v; in_last = l; acc_mode = m;
        a = av[DATA_W-1:0]; b = bv[DATA_W-1:0]; c = cv[DATA_W-1:0];
        if (!e) begin
            foreach (sb_q[i]) if (sb_q[i].due > cyc) sb_q[i].due++;
        end else if (v) begin
            model_beat(l, m, av, bv, cv);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic wait_out(input int ea, input int eb, input int ecnt, input bit eos,
                            input int ewa, input int ewb, input bit eow);
        int k;
        en = 1'b1; in_valid = 1'b0;
        k = 0;
        while (vld_s !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("strobe_seen", vld_s, 1);
        if (vld_s === 1'b1) begin
            check("dir_ac_sat", $signed(ac_s), ea);
            check("dir_bc_sat", $signed(bc_s), eb);
            check("dir_count", cnt_s, ecnt);
            check("dir_ovf_sat", ovf_s, eos);
            check("dir_ac_wrap", $signed(ac_w), ewa);
            check("dir_bc_wrap", $signed(bc_w), ewb);
            check("dir_ovf_wrap", ovf_w, eow);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (vld_s !== vld_w) check("valid_pair", vld_w, vld_s);
            if (vld_s === 1'b1) begin
                n_strobe++;
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", vld_s, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", cyc, e.due);
                    check("ac_sat", $signed(ac_s), e.sa);
                    check("bc_sat", $signed(bc_s), e.sb);
                    check("ac_wrap", $signed(ac_w), e.wa);
                    check("bc_wrap", $signed(bc_w), e.wb);
                    check("count", cnt_s, e.cnt);
                    check("count_wrap", cnt_w, e.cnt);
                    check("ovf_sat", ovf_s, e.os);
                    check("ovf_wrap", ovf_w, e.ow);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (3) @(negedge clk);
        check("rst_ac", ac_s, 0);
        check("rst_bc", bc_s, 0);
        check("rst_count", cnt_s, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_valid", vld_s, 0);
        rst = 1'b0;
        idle(2);

        drive(1, 1, 0, 0, -3, 5, 200);
        wait_out(-600, 1000, 1, 0, -600, 1000, 0);

        drive(1, 1, 0, 0, -128, -128, 255);
        wait_out(-32640, -32640, 1, 0, -32640, -32640, 0);
        drive(1, 1, 0, 0, 127, -128, 0);
        wait_out(0, 0, 1, 0, 0, 0, 0);

        drive(1, 1, 0, 1, 1, 2, 10);
        idle(2);
        drive(1, 1, 0, 1, -4, 3, 5);
        idle(1);
        drive(1, 1, 1, 1, 7, -1, 1);
        wait_out(-3, 34, 3, 0, -3, 34, 0);

        drive(1, 1, 0, 1, 127, 127, 255);
        drive(1, 1, 1, 1, 127, 127, 255);
        wait_out(32767, 32767, 2, 1, -766, -766, 1);
        drive(1, 1, 1, 1, 1, 1, 1);
        wait_out(1, 1, 1, 0, 1, 1, 0);

        drive(1, 1, 0, 1, 2, 3, 4);
        drive(1, 1, 1, 1, 1, 1, 1);
        repeat (5) drive(0, 1, 1, 0, 50, 50, 50);
        wait_out(9, 13, 2, 0, 9, 13, 0);
        idle(1);

        drive(1, 1, 0, 1, 5, 5, 5);
        drive(1, 1, 1, 1, 6, 6, 6);
        drive(1, 1, 0, 1, 9, 9, 9);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ac", ac_s, 0);
        check("mid_rst_bc", bc_s, 0);
        check("mid_rst_count", cnt_s, 0);
        check("mid_rst_ovf", ovf_s, 0);
        check("mid_rst_valid", vld_s, 0);
        n_push -= sb_q.size();
        sb_q.delete();
        m_fresh = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        drive(1, 1, 1, 1, 2, 3, 4);
        wait_out(8, 12, 1, 0, 8, 12, 0);

        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)));
        end
        idle(10);

        check("queue_drain", sb_q.size(), 0);
        check("strobe_count", n_strobe, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
